// File: rtl/iso14443a_miller_decoder.sv
// ISO 14443-A reader-to-card modified-Miller decoder.
// Glitch-filters pause_n, classifies pauses per bit period and assembles bytes/short frames.
module iso14443a_miller_decoder #(
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned X_LO     = 48,
    parameter int unsigned X_HI     = 79,
    parameter int unsigned Z_WIN    = 16
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic       enable,
    input  logic       pause_n,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       short_frame,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_err,
    output logic       last_bit,
    output logic       busy
);
    localparam int unsigned RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic {S_IDLE, S_DATA} state_t;
    typedef enum logic [2:0] {F_NONE, F_BIT0, F_BIT1, F_END, F_ERR} fin_t;

    state_t           r_state, w_state_nxt;
    logic [6:0]       r_cnt, w_cnt_nxt;
    logic             r_sof, w_sof_nxt, r_x, w_x_nxt, r_z, w_z_nxt;
    logic             r_prev_one, w_prev_nxt;
    logic [8:0]       r_bits, w_bits_nxt;
    logic [3:0]       r_nbits, w_nbits_nxt;
    logic             r_byte_seen, w_byte_nxt, r_byte_last, w_blast_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt, r_perr, w_perr_nxt, r_short, w_short_nxt;
    logic             r_fstart, w_fstart_nxt, r_fend, w_fend_nxt, r_ferr, w_ferr_nxt;
    logic             r_last, w_last_nxt;
    logic             r_filt, w_filt_nxt;
    logic [RUN_W-1:0] r_run, w_run_nxt;
    logic             w_fall, w_do_fin, w_open_z, w_abort, w_bit;
    fin_t             w_fin;

    // Glitch filter: flip only after FILT_LEN consecutive samples disagreeing with the filtered state.
    assign w_fall = r_filt & ~pause_n & (r_run == RUN_W'(FILT_LEN - 1));

    always_comb begin
        w_filt_nxt = r_filt;
        w_run_nxt  = '0;
        if (pause_n != r_filt) begin
            if (r_run == RUN_W'(FILT_LEN - 1)) w_filt_nxt = pause_n;
            else                               w_run_nxt  = r_run + RUN_W'(1);
        end
    end

    // Outcome of closing the current bit period from the pause flags seen in it.
    always_comb begin
        if (r_sof)              w_fin = F_NONE;
        else if (r_x && r_z)    w_fin = F_ERR;
        else if (r_x)           w_fin = F_BIT1;
        else if (r_z)           w_fin = F_BIT0;
        else if (r_prev_one)    w_fin = F_BIT0;
        else                    w_fin = F_END;
    end
    assign w_bit = (w_fin == F_BIT1);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sof_nxt    = r_sof;
        w_x_nxt      = r_x;
        w_z_nxt      = r_z;
        w_prev_nxt   = r_prev_one;
        w_bits_nxt   = r_bits;
        w_nbits_nxt  = r_nbits;
        w_byte_nxt   = r_byte_seen;
        w_blast_nxt  = r_byte_last;
        w_data_nxt   = r_data;
        w_perr_nxt   = r_perr;
        w_short_nxt  = r_short;
        w_last_nxt   = r_last;
        w_valid_nxt  = 1'b0;
        w_fstart_nxt = 1'b0;
        w_fend_nxt   = 1'b0;
        w_ferr_nxt   = 1'b0;
        w_do_fin     = 1'b0;
        w_open_z     = 1'b0;
        w_abort      = 1'b0;

        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else if (r_state == S_IDLE) begin
            if (w_fall) begin
                w_state_nxt  = S_DATA;
                w_cnt_nxt    = 7'd0;
                w_sof_nxt    = 1'b1;
                w_fstart_nxt = 1'b1;
            end
        end else begin
            w_cnt_nxt = r_cnt + 7'd1;
            if (w_fall) begin
                if (r_cnt >= 7'(X_LO) && r_cnt <= 7'(X_HI)) begin
                    w_x_nxt   = 1'b1;
                    w_cnt_nxt = 7'd64;
                end else if (r_cnt <= 7'(Z_WIN - 1)) begin
                    if (r_x) begin
                        w_abort = 1'b1;
                    end else begin
                        w_z_nxt   = 1'b1;
                        w_cnt_nxt = 7'd0;
                    end
                end else if (r_cnt >= 7'(128 - Z_WIN)) begin
                    w_do_fin = 1'b1;
                    w_open_z = 1'b1;
                end else begin
                    w_abort = 1'b1;
                end
            end else if (r_cnt == 7'd127) begin
                w_do_fin = 1'b1;
            end

            if (w_do_fin) begin
                w_sof_nxt = 1'b0;
                w_x_nxt   = 1'b0;
                w_z_nxt   = w_open_z;
                w_cnt_nxt = 7'd0;
                case (w_fin)
                    F_BIT0, F_BIT1: begin
                        w_prev_nxt = w_bit;
                        if (r_nbits == 4'd8) begin
                            w_data_nxt  = r_bits[7:0];
                            w_perr_nxt  = ~^{w_bit, r_bits[7:0]};
                            w_short_nxt = 1'b0;
                            w_valid_nxt = 1'b1;
                            w_bits_nxt  = '0;
                            w_nbits_nxt = 4'd0;
                            w_byte_nxt  = 1'b1;
                            w_blast_nxt = w_bit;
                        end else begin
                            w_bits_nxt[r_nbits] = w_bit;
                            w_nbits_nxt         = r_nbits + 4'd1;
                        end
                    end
                    F_END: begin
                        w_state_nxt = S_IDLE;
                        if (!r_byte_seen && r_nbits == 4'd7) begin
                            w_data_nxt  = {1'b0, r_bits[6:0]};
                            w_short_nxt = 1'b1;
                            w_perr_nxt  = 1'b0;
                            w_valid_nxt = 1'b1;
                            w_fend_nxt  = 1'b1;
                            w_last_nxt  = r_bits[6];
                        end else if (r_byte_seen &&
                                     (r_nbits == 4'd0 || (r_nbits == 4'd1 && !r_bits[0]))) begin
                            // A single trailing 0 after a byte is the end-of-frame logic 0.
                            w_fend_nxt = 1'b1;
                            w_last_nxt = r_byte_last;
                        end else begin
                            w_ferr_nxt = 1'b1;
                        end
                    end
                    F_ERR:   w_abort = 1'b1;
                    default: ;
                endcase
            end

            if (w_abort) begin
                w_ferr_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
        end

        if (w_state_nxt == S_IDLE) begin
            w_cnt_nxt   = 7'd0;
            w_sof_nxt   = 1'b0;
            w_x_nxt     = 1'b0;
            w_z_nxt     = 1'b0;
            w_prev_nxt  = 1'b0;
            w_bits_nxt  = '0;
            w_nbits_nxt = 4'd0;
            w_byte_nxt  = 1'b0;
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 7'd0;
            r_sof       <= 1'b0;
            r_x         <= 1'b0;
            r_z         <= 1'b0;
            r_prev_one  <= 1'b0;
            r_bits      <= '0;
            r_nbits     <= 4'd0;
            r_byte_seen <= 1'b0;
            r_byte_last <= 1'b0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_short     <= 1'b0;
            r_fstart    <= 1'b0;
            r_fend      <= 1'b0;
            r_ferr      <= 1'b0;
            r_last      <= 1'b0;
            r_filt      <= 1'b1;
            r_run       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sof       <= w_sof_nxt;
            r_x         <= w_x_nxt;
            r_z         <= w_z_nxt;
            r_prev_one  <= w_prev_nxt;
            r_bits      <= w_bits_nxt;
            r_nbits     <= w_nbits_nxt;
            r_byte_seen <= w_byte_nxt;
            r_byte_last <= w_blast_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_perr      <= w_perr_nxt;
            r_short     <= w_short_nxt;
            r_fstart    <= w_fstart_nxt;
            r_fend      <= w_fend_nxt;
            r_ferr      <= w_ferr_nxt;
            r_last      <= w_last_nxt;
            r_filt      <= w_filt_nxt;
            r_run       <= w_run_nxt;
        end
    end

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign parity_err  = r_perr;
    assign short_frame = r_short;
    assign frame_start = r_fstart;
    assign frame_end   = r_fend;
    assign frame_err   = r_ferr;
    assign last_bit    = r_last;
    assign busy        = (r_state == S_DATA);
endmodule

// File: tb/tb_iso14443a_miller_decoder.sv
// Directed bench for the Miller decoder: frames built from SOF/X/Y/Z periods, strobes tallied on negedge.
module tb_iso14443a_miller_decoder;
    logic       clk = 1'b0;
    logic       rst, enable, pause_n;
    logic [7:0] data_out;
    logic       data_valid, parity_err, short_frame;
    logic       frame_start, frame_end, frame_err, last_bit, busy;

    int checks = 0, failures = 0;
    int n_valid = 0, n_start = 0, n_end = 0, n_err = 0;
    int s_valid, s_start, s_end, s_err;
    logic [7:0] cap_data = 8'h00;
    logic cap_perr = 1'b0, cap_short = 1'b0, cap_fend = 1'b0;

    iso14443a_miller_decoder dut (
        .ck_1356meg (clk),
        .rst        (rst),
        .enable     (enable),
        .pause_n    (pause_n),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .short_frame(short_frame),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .frame_err  (frame_err),
        .last_bit   (last_bit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid   = n_valid + 1;
            cap_data  = data_out;
            cap_perr  = parity_err;
            cap_short = short_frame;
            cap_fend  = frame_end;
        end
        if (frame_start) n_start = n_start + 1;
        if (frame_end)   n_end   = n_end + 1;
        if (frame_err)   n_err   = n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_valid = n_valid; s_start = n_start; s_end = n_end; s_err = n_err;
    endtask

    // One carrier bit period of len cycles with pause_n low for [lo_start, lo_start+lo_len).
    task automatic period(input int lo_start, input int lo_len, input int len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            pause_n = (c >= lo_start && c < lo_start + lo_len) ? 1'b0 : 1'b1;
        end
    endtask

    // SOF, n Miller-coded bits (LSB first), then two idle periods; optional early Z / glitch on a Y.
    task automatic send_frame(input logic [8:0] b, input int n, input int early, input int glitch);
        logic prev;
        int   len;
        prev = 1'b0;
        period(0, 20, (early == 0) ? 118 : 128);
        for (int i = 0; i < n; i++) begin
            len = (i + 1 == early) ? 118 : 128;
            if (b[i])      period(64, 20, len);
            else if (prev) period((i == glitch) ? 30 : 0, (i == glitch) ? 2 : 0, len);
            else           period(0, 20, len);
            prev = b[i];
        end
        period(0, 0, 128);
        period(0, 0, 128);
        period(0, 0, 50);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; pause_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_strobes", 32'({data_valid, parity_err, short_frame, frame_start, frame_end, frame_err}), 32'h0);
        check("rst_last_bit", 32'(last_bit), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // REQA short frame with a 2-cycle glitch inside the Y period of bit 3
        snap();
        send_frame(9'h026, 7, -1, 3);
        check("reqa_start", 32'(n_start - s_start), 32'd1);
        check("reqa_valid", 32'(n_valid - s_valid), 32'd1);
        check("reqa_data", 32'(cap_data), 32'h26);
        check("reqa_short", 32'(cap_short), 32'd1);
        check("reqa_perr", 32'(cap_perr), 32'd0);
        check("reqa_fend_with_valid", 32'(cap_fend), 32'd1);
        check("reqa_end", 32'(n_end - s_end), 32'd1);
        check("reqa_err", 32'(n_err - s_err), 32'd0);
        check("reqa_last_bit", 32'(last_bit), 32'd0);
        check("reqa_busy", 32'(busy), 32'd0);

        // 0x93 with correct odd parity 1
        snap();
        send_frame(9'h193, 9, -1, -1);
        check("b93p1_valid", 32'(n_valid - s_valid), 32'd1);
        check("b93p1_data", 32'(cap_data), 32'h93);
        check("b93p1_perr", 32'(cap_perr), 32'd0);
        check("b93p1_short", 32'(cap_short), 32'd0);
        check("b93p1_end", 32'(n_end - s_end), 32'd1);
        check("b93p1_err", 32'(n_err - s_err), 32'd0);
        check("b93p1_last_bit", 32'(last_bit), 32'd1);

        // 0x93 with wrong parity 0
        snap();
        send_frame(9'h093, 9, -1, -1);
        check("b93p0_valid", 32'(n_valid - s_valid), 32'd1);
        check("b93p0_data", 32'(cap_data), 32'h93);
        check("b93p0_perr", 32'(cap_perr), 32'd1);
        check("b93p0_end", 32'(n_end - s_end), 32'd1);
        check("b93p0_last_bit", 32'(last_bit), 32'd0);

        // pause landing at cnt=30 of the first data period
        snap();
        period(0, 20, 128);
        period(31, 20, 128);
        period(0, 0, 50);
        check("cnt30_err", 32'(n_err - s_err), 32'd1);
        check("cnt30_valid", 32'(n_valid - s_valid), 32'd0);
        check("cnt30_end", 32'(n_end - s_end), 32'd0);
        check("cnt30_busy", 32'(busy), 32'd0);

        // enable dropped mid-frame
        snap();
        period(0, 20, 128);
        period(64, 20, 128);
        period(0, 0, 40);
        check("en_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); @(negedge clk);
        check("en_busy_after", 32'(busy), 32'd0);
        period(0, 0, 300);
        enable = 1'b1;
        check("en_no_err", 32'(n_err - s_err), 32'd0);
        check("en_no_end_valid", 32'((n_end - s_end) + (n_valid - s_valid)), 32'd0);

        // Z pause for bit 3 arrives 10 cycles early
        snap();
        send_frame(9'h193, 9, 3, -1);
        check("early_valid", 32'(n_valid - s_valid), 32'd1);
        check("early_data", 32'(cap_data), 32'h93);
        check("early_perr", 32'(cap_perr), 32'd0);
        check("early_end", 32'(n_end - s_end), 32'd1);
        check("early_last_bit", 32'(last_bit), 32'd1);

        // reset for one cycle after four bits of a REQA
        period(0, 20, 128);
        period(0, 20, 128);
        period(64, 20, 128);
        period(64, 20, 128);
        period(0, 0, 128);
        snap();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_outs", 32'({data_out, data_valid, parity_err, short_frame, frame_start, frame_end, frame_err}), 32'h0);
        check("mrst_last_bit", 32'(last_bit), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        period(0, 0, 400);
        check("mrst_no_strobes", 32'((n_valid - s_valid) + (n_start - s_start) + (n_end - s_end) + (n_err - s_err)), 32'd0);
        snap();
        send_frame(9'h026, 7, -1, -1);
        check("mrst_reqa_valid", 32'(n_valid - s_valid), 32'd1);
        check("mrst_reqa_data", 32'(cap_data), 32'h26);
        check("mrst_reqa_end", 32'(n_end - s_end), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
